// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: segment width, hex pattern
// table (a..g, a as MSB), FSM encoding and the lookup result type.
package seg7_pkg;
  localparam int SEG_W = 7;

  // Entry i is the segment pattern that displays hex digit i.
  localparam logic [15:0][SEG_W-1:0] HEX_PAT = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_TRACK = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] val;
  } dec_t;
endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational reverse lookup: segment pattern -> hex value plus hit flag.
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pat,
  output dec_t             dec
);
  always_comb begin
    dec = '0;
    for (int i = 0; i < 16; i++) begin
      if (pat == HEX_PAT[i]) begin
        dec.hit = 1'b1;
        dec.val = 4'(i);
      end
    end
  end
endmodule

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed 7-segment bus, captures each digit slot once its
// sample has been stable for STABLE_CYCLES edges, and decodes it back to hex.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS    = 4,
  parameter  int STABLE_CYCLES = 3,
  localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SEG_W-1:0]        seg,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    pat_err,
  output logic [2:0]              err_digit,
  output logic                    frame_done
);
  localparam int SW = SEG_W + NUM_DIGITS;

  state_t                         state, state_nxt;
  logic [CNT_W-1:0]               cnt, cnt_nxt;
  logic [SW-1:0]                  prev, smp;
  logic                           onehot, same, at_stable, cap;
  logic [CNT_W:0]                 cnt_inc;
  logic [2:0]                     slot;
  logic [NUM_DIGITS-1:0]          seen, cap_mask;
  logic [NUM_DIGITS-1:0][3:0]     digits_r;
  dec_t                           dec;

  assign smp       = {seg, dig_en};
  assign same      = (smp == prev);
  assign onehot    = (dig_en != '0) && ((dig_en & (dig_en - NUM_DIGITS'(1))) == '0);
  assign cnt_inc   = {1'b0, cnt} + (CNT_W + 1)'(1);
  assign at_stable = (cnt_inc == (CNT_W + 1)'(STABLE_CYCLES));
  assign digits    = digits_r;

  seg7_pattern_lookup u_lookup (.pat(seg), .dec(dec));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_BLANK;
      cnt   <= '0;
      prev  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      prev  <= smp;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!onehot) begin
      state_nxt = ST_BLANK;
      cnt_nxt   = '0;
    end else if (state == ST_TRACK && same) begin
      if (at_stable) begin
        state_nxt = ST_HELD;
        cnt_nxt   = CNT_W'(STABLE_CYCLES);
      end else begin
        cnt_nxt   = cnt_inc[CNT_W-1:0];
      end
    end else if (state == ST_HELD && same) begin
      state_nxt = ST_HELD;
    end else begin
      // Fresh one-hot sample; with a single-sample window it is already stable.
      state_nxt = (STABLE_CYCLES == 1) ? ST_HELD : ST_TRACK;
      cnt_nxt   = CNT_W'(1);
    end
  end

  // Entering HELD from anything other than a steady HELD is a capture.
  always_comb begin
    cap      = (state_nxt == ST_HELD) && !(state == ST_HELD && same);
    cap_mask = cap ? dig_en : '0;
    slot     = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (dig_en[i]) slot = 3'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_r    <= '0;
      digit_valid <= '0;
      pat_err     <= 1'b0;
      err_digit   <= '0;
      frame_done  <= 1'b0;
      seen        <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_mask[i]) begin
          if (dec.hit) digits_r[i] <= dec.val;
          digit_valid[i] <= dec.hit;
        end
      end
      pat_err    <= cap && !dec.hit;
      if (cap && !dec.hit) err_digit <= slot;
      frame_done <= &seen;
      seen       <= ((&seen) ? '0 : seen) | cap_mask;
    end
  end
endmodule
